mem_access_stage: RTL

//  MEM pipeline stage; consumes the EX/MEM register outputs.

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_access_stage_mem_wb_reg.sv | 23 ++
 rtl/mem_access_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: FSM encoding, wait-counter width and
// the MEM/WB bubble value.
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  rd;
    } mem_wb_t;

    // A bubble clears every MEM/WB field, so WB never writes the register file.
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register: loads every cycle, either the new fields or a
// bubble. Synchronous active-high reset.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic    Clk,
    input  logic    Rst,
    input  logic    bubble,
    input  mem_wb_t wb_in,
    output mem_wb_t wb_q
);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wb_q <= MEM_WB_BUBBLE;
        end else if (bubble) begin
            wb_q <= MEM_WB_BUBBLE;
        end else begin
            wb_q <= wb_in;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory access over req/ack, branch/jump redirect,
// upstream stall and MEM/WB register. Optional macro: MEM_MISALIGN_CHECK_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RegWrite_In,
    input  logic        MemToReg_In,
    input  logic        Branch_In,
    input  logic        MemRead_In,
    input  logic        MemWrite_In,
    input  logic        Jump_In,
    input  logic [31:0] JumpAddr_In,
    input  logic [31:0] BranchAddr_In,
    input  logic        ALUZero_In,
    input  logic [31:0] ALUResult_In,
    input  logic [31:0] ReadData2_In,
    input  logic [4:0]  EX_MEM_Rd_In,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWData,
    input  logic        DMemAck,
    input  logic [31:0] DMemRData,
    output logic        Stall_Out,
    output logic        PCSrc_Out,
    output logic [31:0] Target_Out,
    output logic        MemErr_Out,
    output logic        MisalignErr_Out,
    output logic        RegWrite_Out,
    output logic        MemToReg_Out,
    output logic [31:0] ReadData_Out,
    output logic [31:0] ALUResult_Out,
    output logic [4:0]  MEM_WB_Rd_Out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Handshake: DMemReq rises with a stable payload and stays up, payload
    // unchanged, until the cycle DMemAck pulses (or the wait times out);
    // DMemRData is only sampled in that ack cycle. Acks while idle are ignored.
    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             mem_op, misalign;
    logic             issue, complete, timeout, wb_bubble;
    logic [31:0]      ld_data;
    mem_wb_t          wb_in, wb_q;

    assign mem_op = MemRead_In | MemWrite_In;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = mem_op & (ALUResult_In[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign MisalignErr_Out = (state == IDLE) & misalign;

    assign PCSrc_Out  = Jump_In | (Branch_In & ALUZero_In);
    assign Target_Out = Jump_In ? JumpAddr_In : BranchAddr_In;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        Stall_Out    = 1'b0;
        wb_bubble    = 1'b0;
        issue        = 1'b0;
        complete     = 1'b0;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                if (misalign) begin
                    wb_bubble = 1'b1;
                end else if (mem_op) begin
                    Stall_Out    = 1'b1;
                    wb_bubble    = 1'b1;
                    issue        = 1'b1;
                    wait_cnt_nxt = '0;
                    state_nxt    = ACCESS;
                end
            end
            ACCESS: begin
                if (DMemAck) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    wb_bubble = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    Stall_Out    = 1'b1;
                    wb_bubble    = 1'b1;
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            DMemReq    <= 1'b0;
            DMemWe     <= 1'b0;
            DMemAddr   <= '0;
            DMemWData  <= '0;
            MemErr_Out <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (issue) begin
                DMemReq   <= 1'b1;
                DMemWe    <= MemWrite_In;
                DMemAddr  <= ALUResult_In;
                DMemWData <= ReadData2_In;
            end else if (complete || timeout) begin
                DMemReq <= 1'b0;
            end
            if (timeout) begin
                MemErr_Out <= 1'b1;
            end
        end
    end

    // Stores (including read+write) retire with zero read data.
    assign ld_data = (state == ACCESS && DMemAck && !MemWrite_In) ? DMemRData : '0;

    always_comb begin
        wb_in            = MEM_WB_BUBBLE;
        wb_in.reg_write  = RegWrite_In;
        wb_in.mem_to_reg = MemToReg_In;
        wb_in.read_data  = ld_data;
        wb_in.alu_result = ALUResult_In;
        wb_in.rd         = EX_MEM_Rd_In;
    end

    mem_wb_reg u_mem_wb_reg (
        .Clk    (Clk),
        .Rst    (Rst),
        .bubble (wb_bubble),
        .wb_in  (wb_in),
        .wb_q   (wb_q)
    );

    assign RegWrite_Out  = wb_q.reg_write;
    assign MemToReg_Out  = wb_q.mem_to_reg;
    assign ReadData_Out  = wb_q.read_data;
    assign ALUResult_Out = wb_q.alu_result;
    assign MEM_WB_Rd_Out = wb_q.rd;

endmodule
